// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: controller state encoding
// and a constant clog2 used to size the iteration counter.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions for register widths.
    function automatic int clog2(input int value);
        int r_bits;
        int r_v;
        r_bits = 0;
        r_v    = value - 1;
        while (r_v > 0) begin
            r_bits++;
            r_v = r_v >> 1;
        end
        return r_bits;
    endfunction

endpackage

// File: rtl/fullLookaheadAdder.sv
// N-bit combinational adder with fully expanded carry lookahead: every carry
// is a flat sum of generate/propagate products rather than a ripple chain.
module fullLookaheadAdder #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         ci,
    output logic [N-1:0] S,
    output logic         co
);

    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N:0]   w_c;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]ci, expanded per bit.
    always_comb begin
        logic w_term;
        // NOTE: every variable written here gets a default first so no path leaves it holding a stale value (no latch).
        w_c    = '0;
        w_term = 1'b0;
        w_c[0] = ci;
        for (int i = 0; i < N; i++) begin
            w_term = ci;
            for (int j = 0; j <= i; j++) begin
                w_term = w_term & w_p[j];
            end
            w_c[i+1] = w_term;
            for (int j = 0; j <= i; j++) begin
                w_term = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    w_term = w_term & w_p[k];
                end
                w_c[i+1] = w_c[i+1] | w_term;
            end
        end
    end

    assign S  = w_p ^ w_c[N-1:0];
    assign co = w_c[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N shift-add multiplier with start/busy/done handshake;
// one lookahead adder accumulates a partial product each cycle for N cycles.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = clog2(N + 1);

    state_t           r_state;
    logic [N-1:0]     r_acc;
    logic [N-1:0]     r_mq;
    logic [N-1:0]     r_mcand;
    logic [CW-1:0]    r_count;
    logic [2*N-1:0]   r_product;

    logic [N-1:0]     w_addend;
    logic [N-1:0]     w_sum;
    logic             w_co;
    logic [2*N-1:0]   w_shifted;

    assign w_addend = r_mq[0] ? r_mcand : '0;

    fullLookaheadAdder #(.N(N)) u_adder (
        .A  (r_acc),
        .B  (w_addend),
        .ci (1'b0),
        .S  (w_sum),
        .co (w_co)
    );

    // Right shift of {co,S,mq}: the adder carry lands in acc's MSB, so no bit is lost.
    assign w_shifted = {w_co, w_sum, r_mq[N-1:1]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_mq      <= '0;
            r_mcand   <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_mcand <= a;
                        r_mq    <= b;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    {r_acc, r_mq} <= w_shifted;
                    r_count       <= r_count + CW'(1);
                    if (r_count == CW'(N - 1)) begin
                        r_product <= w_shifted;
                        r_state   <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: directed corners plus randomized operands, compared
// against plain integer multiplication; exhaustive sweep on an N=4 instance.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        busy4;
    logic        done4;
    logic [7:0]  product4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    shift_add_multiplier #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(product4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait for the end of RUN; leaves the bench in the done cycle.
    task automatic do_mult(input logic [7:0] x, input logic [7:0] y, output int bcyc);
        a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        bcyc = 0;
        while (busy && bcyc < 100) begin
            bcyc++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        tick(); tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, product} !== 18'd0) $display("FAIL reset_state: got busy=%b done=%b product=%0d, want 0 0 0", busy, done, product);
        else n_pass++;
        n_checks++;
        if ({busy4, done4, product4} !== 10'd0) $display("FAIL reset_state_n4: got busy=%b done=%b product=%0d, want 0 0 0", busy4, done4, product4);
        else n_pass++;
    endtask

    task automatic test_basic();
        int bcyc;
        do_mult(8'd13, 8'd11, bcyc);
        n_checks++;
        if (bcyc !== 8) $display("FAIL basic_busy_len: got %0d cycles, want 8", bcyc);
        else n_pass++;
        n_checks++;
        if (done !== 1'b1 || product !== 16'd143) $display("FAIL basic_product: got done=%b product=%0d, want 1 143", done, product);
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== 16'd143) $display("FAIL basic_done_pulse: got done=%b busy=%b product=%0d, want 0 0 143", done, busy, product);
        else n_pass++;
    endtask

    task automatic test_corners();
        logic [7:0] xs [4] = '{8'd255, 8'd0,   8'd255, 8'd128};
        logic [7:0] ys [4] = '{8'd255, 8'd255, 8'd1,   8'd2};
        int bcyc;
        for (int i = 0; i < 4; i++) begin
            do_mult(xs[i], ys[i], bcyc);
            n_checks++;
            if (done !== 1'b1 || product !== 16'(int'(xs[i]) * int'(ys[i])))
                $display("FAIL corner_%0d: got done=%b product=%0d, want 1 %0d", i, done, product, int'(xs[i]) * int'(ys[i]));
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int bcyc;
        int extra_done;
        a = 8'd200; b = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'd5; b = 8'd5; start = 1'b1;
        tick();
        start = 1'b0; a = 8'd0; b = 8'd0;
        bcyc = 3;
        while (busy && bcyc < 100) begin
            bcyc++;
            tick();
        end
        n_checks++;
        if (bcyc !== 8) $display("FAIL ignore_busy_len: got %0d cycles, want 8", bcyc);
        else n_pass++;
        n_checks++;
        if (done !== 1'b1 || product !== 16'd600) $display("FAIL ignore_product: got done=%b product=%0d, want 1 600", done, product);
        else n_pass++;
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) extra_done++;
        end
        n_checks++;
        if (extra_done !== 0) $display("FAIL ignore_no_rerun: got %0d busy/done cycles, want 0", extra_done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bcyc;
        int held_bad;
        do_mult(8'd7, 8'd9, bcyc);
        n_checks++;
        if (done !== 1'b1 || product !== 16'd63) $display("FAIL b2b_first: got done=%b product=%0d, want 1 63", done, product);
        else n_pass++;
        a = 8'd17; b = 8'd19; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy, done);
        else n_pass++;
        bcyc = 0; held_bad = 0;
        while (busy && bcyc < 100) begin
            if (product !== 16'd63) held_bad++;
            bcyc++;
            tick();
        end
        n_checks++;
        if (bcyc !== 8 || held_bad !== 0) $display("FAIL b2b_hold: got %0d busy cycles, %0d with product!=63, want 8 0", bcyc, held_bad);
        else n_pass++;
        n_checks++;
        if (done !== 1'b1 || product !== 16'd323) $display("FAIL b2b_second: got done=%b product=%0d, want 1 323", done, product);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int bcyc;
        int seen_done;
        a = 8'd100; b = 8'd100; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'd0) $display("FAIL midrun_reset: got busy=%b done=%b product=%0d, want 0 0 0", busy, done, product);
        else n_pass++;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) seen_done++;
            tick();
        end
        n_checks++;
        if (seen_done !== 0) $display("FAIL midrun_no_done: got %0d busy/done cycles, want 0", seen_done);
        else n_pass++;
        do_mult(8'd3, 8'd4, bcyc);
        n_checks++;
        if (done !== 1'b1 || product !== 16'd12) $display("FAIL midrun_after: got done=%b product=%0d, want 1 12", done, product);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int bcyc;
        logic [7:0] x;
        logic [7:0] y;
        for (int i = 0; i < 30; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            do_mult(x, y, bcyc);
            n_checks++;
            if (done !== 1'b1 || bcyc !== 8 || product !== 16'(int'(x) * int'(y)))
                $display("FAIL random_%0d: %0d*%0d got done=%b busy_len=%0d product=%0d, want 1 8 %0d", i, x, y, done, bcyc, product, int'(x) * int'(y));
            else n_pass++;
            // Roughly half the time launch the next operation straight from DONE.
            if ($urandom_range(0, 1) == 0) tick();
        end
        tick();
    endtask

    task automatic test_exhaustive_n4();
        int waited;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
                tick();
                start4 = 1'b0;
                waited = 0;
                while (!done4 && waited < 20) begin
                    waited++;
                    tick();
                end
                n_checks++;
                if (done4 !== 1'b1 || waited !== 4 || product4 !== 8'(x * y))
                    $display("FAIL n4_%0dx%0d: got done=%b cycles=%0d product=%0d, want 1 4 %0d", x, y, done4, waited, product4, x * y);
                else n_pass++;
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_exhaustive_n4();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
